// File: rtl/lot_access_controller_pkg.sv
// Shared definitions for the parking-lot access controller: FSM encoding, count direction
// and the round-robin picker used by both the entry and the exit arbitration classes.
package lot_pkg;

   localparam logic [1:0] StArb  = 2'd0;
   localparam logic [1:0] StUpd  = 2'd1;
   localparam logic [1:0] StWait = 2'd2;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int unsigned MaxGates = 8;

   // Returns {found, index}: lowest requesting index at or after ptr, wrapping at n_gates.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                          input int unsigned n_gates);
      logic        found;
      logic [2:0]  idx;
      int unsigned cand;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < MaxGates; i++) begin
         cand = (32'(ptr) + i) % n_gates;
         if (i < n_gates && !found && req[cand[2:0]]) begin
            found = 1'b1;
            idx   = cand[2:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/lot_access_controller_if.sv
// Gate-event and occupancy-counter bundle between the sensor/counter side and the controller.
interface lot_access_controller_if #(
   parameter int unsigned N = 8,
   parameter int unsigned G = 2
);
   logic [G-1:0] entry_evt;
   logic [G-1:0] exit_evt;
   logic [N-1:0] count;
   logic         cnt_en;
   logic         cnt_dir;
   logic [G-1:0] gate_open;
   logic         lot_full;
   logic         underflow_err;

   modport master (
      output entry_evt, exit_evt, count,
      input  cnt_en, cnt_dir, gate_open, lot_full, underflow_err
   );

   modport slave (
      input  entry_evt, exit_evt, count,
      output cnt_en, cnt_dir, gate_open, lot_full, underflow_err
   );
endinterface

// File: rtl/lot_access_controller_gate_barrier_timer.sv
// Per-gate barrier timer: open for exactly OPEN_CYC cycles starting with the load cycle;
// a load while open restarts the full window.
module gate_barrier_timer
   import lot_pkg::*;
#(
   parameter int unsigned OPEN_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   output logic open_o
);
   localparam int unsigned TW = $clog2(OPEN_CYC + 1);

   logic [TW-1:0] timer_q, timer_d;

   // The load cycle itself is the first open cycle, so only OPEN_CYC-1 remain afterwards.
   always_comb begin
      timer_d = timer_q;
      if (load_i) begin
         timer_d = TW'(OPEN_CYC - 1);
      end else if (timer_q != '0) begin
         timer_d = timer_q - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign open_o = load_i | (timer_q != '0);

endmodule

// File: rtl/lot_access_controller.sv
// Arbitrates per-gate entry/exit events onto one shared occupancy counter, one update per
// three cycles, holding entries while the lot is full and driving a timed barrier per gate.
module lot_access_controller
   import lot_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned G        = 2,
   parameter int unsigned CAP      = 200,
   parameter int unsigned OPEN_CYC = 16
) (
   input logic                    clk,
   input logic                    reset,
   lot_access_controller_if.slave bus
);
   logic [G-1:0] entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
   logic [G-1:0] entry_clr, exit_clr, load, gate_open;
   logic [1:0]   state_q, state_d;
   logic [2:0]   grant_id_q, grant_id_d, grant_next;
   logic [2:0]   rr_entry_q, rr_entry_d, rr_exit_q, rr_exit_d;
   logic         grant_dir_q, grant_dir_d;
   logic [3:0]   pick_entry, pick_exit;
   logic         below_cap, upd_drop;

   assign below_cap  = bus.count < N'(CAP);
   assign pick_entry = rr_pick(8'(entry_pend_q), rr_entry_q, G);
   assign pick_exit  = rr_pick(8'(exit_pend_q), rr_exit_q, G);
   assign grant_next = 3'((32'(grant_id_q) + 1) % G);

   // An exit granted against an empty lot is dropped and reported instead of counted.
   assign upd_drop = (state_q == StUpd) && (grant_dir_q == DIR_DN) && (bus.count == '0);

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      grant_dir_d = grant_dir_q;
      rr_entry_d  = rr_entry_q;
      rr_exit_d   = rr_exit_q;
      entry_clr   = '0;
      exit_clr    = '0;
      case (state_q)
         StArb: begin
            if (pick_exit[3]) begin
               grant_id_d  = pick_exit[2:0];
               grant_dir_d = DIR_DN;
               exit_clr    = G'(1) << pick_exit[2:0];
               state_d     = StUpd;
            end else if (pick_entry[3] && below_cap) begin
               grant_id_d  = pick_entry[2:0];
               grant_dir_d = DIR_UP;
               entry_clr   = G'(1) << pick_entry[2:0];
               state_d     = StUpd;
            end
         end
         StUpd: begin
            if (grant_dir_q == DIR_DN) begin
               rr_exit_d = grant_next;
            end else begin
               rr_entry_d = grant_next;
            end
            state_d = StWait;
         end
         default: state_d = StArb;
      endcase
      // A pulse arriving on the bit being granted survives as a fresh pending event.
      entry_pend_d = (entry_pend_q & ~entry_clr) | bus.entry_evt;
      exit_pend_d  = (exit_pend_q & ~exit_clr) | bus.exit_evt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StArb;
         entry_pend_q <= '0;
         exit_pend_q  <= '0;
         grant_id_q   <= '0;
         grant_dir_q  <= DIR_DN;
         rr_entry_q   <= '0;
         rr_exit_q    <= '0;
      end else begin
         state_q      <= state_d;
         entry_pend_q <= entry_pend_d;
         exit_pend_q  <= exit_pend_d;
         grant_id_q   <= grant_id_d;
         grant_dir_q  <= grant_dir_d;
         rr_entry_q   <= rr_entry_d;
         rr_exit_q    <= rr_exit_d;
      end
   end

   always_comb begin
      load = '0;
      for (int g = 0; g < int'(G); g++) begin
         load[g] = (state_q == StUpd) && (grant_dir_q == DIR_UP) && (grant_id_q == 3'(g));
      end
   end

   for (genvar g = 0; g < G; g++) begin : g_gate
      gate_barrier_timer #(
         .OPEN_CYC(OPEN_CYC)
      ) u_timer (
         .clk   (clk),
         .reset (reset),
         .load_i(load[g]),
         .open_o(gate_open[g])
      );
   end

   assign bus.gate_open     = gate_open;
   assign bus.cnt_en        = (state_q == StUpd) && !upd_drop;
   assign bus.cnt_dir       = (state_q == StUpd) && !upd_drop && grant_dir_q;
   assign bus.underflow_err = upd_drop;
   assign bus.lot_full      = ~below_cap;

endmodule

// File: tb/tb_lot_access_controller.sv
// Scoreboard bench: batches of gate events are resolved by a transaction-level lot model into
// an ordered list of expected counter strobes that a negedge monitor checks cycle by cycle.
module tb_lot_access_controller;
   localparam int unsigned N    = 8;
   localparam int unsigned G    = 2;
   localparam int unsigned CAP  = 3;
   localparam int unsigned OPEN = 6;

   localparam int KUp = 0;
   localparam int KDn = 1;
   localparam int KUf = 2;

   typedef struct {
      int kind;
      int gate;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic load_cnt;
   logic [N-1:0] load_val;
   bit   mon_en = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   exp_t exp_q[$];
   int   open_until[G] = '{default: -1};

   // Lot model state: occupancy, held entries and the two rotation starting points.
   int          mcount = 0;
   logic [G-1:0] mpend = '0;
   int          ptr_en = 0;
   int          ptr_ex = 0;

   lot_access_controller_if #(.N(N), .G(G)) bus ();

   lot_access_controller #(
      .N       (N),
      .G       (G),
      .CAP     (CAP),
      .OPEN_CYC(OPEN)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Occupancy counter driven by the controller's strobes.
   always @(posedge clk) begin
      if (load_cnt) begin
         bus.count <= load_val;
      end else if (bus.cnt_en) begin
         bus.count <= bus.cnt_dir ? bus.count + N'(1) : bus.count - N'(1);
      end
   end

   function automatic void chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endfunction

   exp_t mon_e;
   int   mon_kind;
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.cnt_en || bus.underflow_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.cnt_en && bus.underflow_err) mon_kind = 3;
               else if (bus.underflow_err) mon_kind = KUf;
               else mon_kind = bus.cnt_dir ? KUp : KDn;
               chk("strobe_kind", mon_kind, mon_e.kind);
               chk("strobe_cycle", cyc, mon_e.cyc);
               if (mon_e.kind == KUp) open_until[mon_e.gate] = cyc + int'(OPEN) - 1;
            end
         end
         if (!bus.cnt_en) chk("cnt_dir_idle", int'(bus.cnt_dir), 0);
         chk("lot_full", int'(bus.lot_full), int'(bus.count >= N'(CAP)));
         for (int g = 0; g < int'(G); g++) begin
            chk("gate_open", int'(bus.gate_open[g]), int'(open_until[g] >= cyc));
         end
         if (reset) begin
            exp_q.delete();
            for (int g = 0; g < int'(G); g++) open_until[g] = -1;
         end
      end
   end

   task automatic set_count(input int v);
      @(posedge clk);
      #1;
      load_cnt = 1'b1;
      load_val = N'(v);
      @(posedge clk);
      #1;
      load_cnt = 1'b0;
      mcount   = v;
   endtask

   // Pulse a set of events in one cycle; exits resolve first, then entries while below CAP.
   task automatic run_batch(input logic [G-1:0] en, input logic [G-1:0] ex, input int gap);
      int   t, k, g, p0, settle;
      exp_t e;
      @(posedge clk);
      #1;
      t  = cyc;
      k  = 0;
      p0 = ptr_ex;
      for (int i = 0; i < int'(G); i++) begin
         g = (p0 + i) % int'(G);
         if (ex[g]) begin
            e.gate = g;
            e.cyc  = t + 2 + 3 * k;
            if (mcount == 0) begin
               e.kind = KUf;
            end else begin
               e.kind = KDn;
               mcount--;
            end
            exp_q.push_back(e);
            ptr_ex = (g + 1) % int'(G);
            k++;
         end
      end
      mpend = mpend | en;
      p0    = ptr_en;
      for (int i = 0; i < int'(G); i++) begin
         g = (p0 + i) % int'(G);
         if (mpend[g]) begin
            if (mcount >= int'(CAP)) break;
            e.gate = g;
            e.cyc  = t + 2 + 3 * k;
            e.kind = KUp;
            exp_q.push_back(e);
            mcount++;
            mpend[g] = 1'b0;
            ptr_en   = (g + 1) % int'(G);
            k++;
         end
      end
      bus.entry_evt = en;
      bus.exit_evt  = ex;
      @(posedge clk);
      #1;
      bus.entry_evt = '0;
      bus.exit_evt  = '0;
      settle = (k == 0) ? 1 : 3 * k;
      repeat (settle - 1 + gap) @(posedge clk);
      #1;
      chk("count", int'(bus.count), mcount);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      int   t;
      exp_t e;
      reset         = 1'b1;
      load_cnt      = 1'b1;
      load_val      = '0;
      bus.entry_evt = '0;
      bus.exit_evt  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      load_cnt = 1'b0;
      mon_en   = 1'b1;
      chk("rst_cnt_en", int'(bus.cnt_en), 0);
      chk("rst_cnt_dir", int'(bus.cnt_dir), 0);
      chk("rst_gate_open", int'(bus.gate_open), 0);
      chk("rst_underflow", int'(bus.underflow_err), 0);

      // Single entry, then exit-before-entry priority.
      run_batch(2'b01, 2'b00, 20);
      set_count(2);
      run_batch(2'b10, 2'b01, 10);

      // Round-robin on simultaneous entries, twice.
      set_count(0);
      run_batch(2'b11, 2'b00, 10);
      set_count(0);
      run_batch(2'b11, 2'b00, 10);

      // Full lot holds the entry until an exit frees a slot.
      set_count(3);
      run_batch(2'b01, 2'b00, 5);
      chk("held_full", int'(bus.lot_full), 1);
      run_batch(2'b00, 2'b10, 10);

      // Exit on an empty lot.
      set_count(0);
      run_batch(2'b00, 2'b01, 5);

      // Reset during the UPD of a gate1 entry while gate0's entry is pending.
      set_count(0);
      @(posedge clk);
      #1;
      t      = cyc;
      e.kind = KUp;
      e.gate = 1;
      e.cyc  = t + 2;
      exp_q.push_back(e);
      bus.entry_evt = 2'b10;
      @(posedge clk);
      #1;
      bus.entry_evt = 2'b01;
      @(posedge clk);
      #1;
      bus.entry_evt = 2'b00;
      reset         = 1'b1;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mcount = mcount + 1;
      mpend  = '0;
      ptr_en = 0;
      ptr_ex = 0;
      chk("rst_mid_outs", int'({bus.cnt_en, bus.underflow_err, bus.gate_open}), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_mid_count", int'(bus.count), mcount);

      // Randomized batches; short gaps let barrier windows overlap and reload.
      for (int n = 0; n < 80; n++) begin
         run_batch(G'($urandom_range(0, 3)), G'($urandom_range(0, 3)),
                   int'($urandom_range(0, 6)));
      end

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
